// File: rtl/hex_frame_serializer_if.sv
// Sample-in / byte-out stream bundle for hex_frame_serializer.
// master = the environment side, slave = the serializer.
interface hex_frame_serializer_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned WIDTH    = 16
);
  logic                        s_valid;
  logic                        s_ready;
  logic [CHANNELS*WIDTH-1:0]   s_data;
  logic                        m_valid;
  logic                        m_ready;
  logic [7:0]                  m_data;
  logic                        m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/hex_frame_serializer.sv
// Captures one multi-channel sample and streams it out as "<h..h|h..h>\n" ASCII-hex bytes.
// Define HEX_FRAME_SERIALIZER_CK_EN to insert a "*XX" XOR checksum field before '>'.
module hex_frame_serializer #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hex_frame_serializer_if.slave bus,
  output logic [15:0]          frame_count
);
  localparam int unsigned Digits = WIDTH / 4;
  localparam int unsigned ChW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DigW   = (Digits > 1) ? $clog2(Digits) : 1;
  localparam logic [ChW-1:0]  LastCh  = ChW'(CHANNELS - 1);
  localparam logic [DigW-1:0] LastDig = DigW'(Digits - 1);

  typedef enum logic {StIdle, StSend} state_e;
  typedef enum logic [2:0] {
    PhStart, PhDigit, PhSep, PhCkStar, PhCkHi, PhCkLo, PhEnd, PhNl
  } phase_e;

  state_e                    state_q, state_d;
  phase_e                    phase_q, phase_d;
  logic [ChW-1:0]            ch_q, ch_d;
  logic [DigW-1:0]           dig_q, dig_d;
  logic [WIDTH-1:0]          cur_q;
  logic [CHANNELS*WIDTH-1:0] rest_q;
  logic [15:0]               frame_count_q;
  logic [7:0]                byte_val;
  logic                      capture, accept, frame_done;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign capture     = bus.s_valid & bus.s_ready;
  assign accept      = bus.m_valid & bus.m_ready;
  assign frame_done  = accept & (phase_q == PhNl);
  assign frame_count = frame_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (capture) state_d = StSend;
      StSend:  if (frame_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // s_ready is gated by rst so nothing is offered while reset is held.
  always_comb begin
    bus.s_ready = (state_q == StIdle) & ~rst;
    bus.m_valid = (state_q == StSend);
    bus.m_last  = (state_q == StSend) & (phase_q == PhNl);
    bus.m_data  = (state_q == StSend) ? byte_val : 8'h00;
  end

  always_comb begin
    phase_d = phase_q;
    ch_d    = ch_q;
    dig_d   = dig_q;
    if (capture) begin
      phase_d = PhStart;
      ch_d    = '0;
      dig_d   = '0;
    end else if (accept) begin
      case (phase_q)
        PhStart: phase_d = PhDigit;
        PhDigit: begin
          if (dig_q == LastDig) begin
            dig_d = '0;
            if (ch_q == LastCh) begin
`ifdef HEX_FRAME_SERIALIZER_CK_EN
              phase_d = PhCkStar;
`else
              phase_d = PhEnd;
`endif
            end else begin
              phase_d = PhSep;
            end
          end else begin
            dig_d = dig_q + 1'b1;
          end
        end
        PhSep: begin
          ch_d    = ch_q + 1'b1;
          phase_d = PhDigit;
        end
        PhCkStar: phase_d = PhCkHi;
        PhCkHi:   phase_d = PhCkLo;
        PhCkLo:   phase_d = PhEnd;
        PhEnd:    phase_d = PhNl;
        default:  phase_d = PhStart;
      endcase
    end
  end

  // cur_q holds the channel being printed, MSB nibble on top; rest_q queues later channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= PhStart;
      ch_q          <= '0;
      dig_q         <= '0;
      cur_q         <= '0;
      rest_q        <= '0;
      frame_count_q <= 16'h0000;
    end else begin
      phase_q <= phase_d;
      ch_q    <= ch_d;
      dig_q   <= dig_d;
      if (capture) begin
        cur_q  <= bus.s_data[WIDTH-1:0];
        rest_q <= bus.s_data >> WIDTH;
      end else if (accept && phase_q == PhDigit) begin
        cur_q <= cur_q << 4;
      end else if (accept && phase_q == PhSep) begin
        cur_q  <= rest_q[WIDTH-1:0];
        rest_q <= rest_q >> WIDTH;
      end
      if (frame_done) frame_count_q <= frame_count_q + 16'd1;
    end
  end

`ifdef HEX_FRAME_SERIALIZER_CK_EN
  logic [7:0] ck_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_q <= 8'h00;
    end else if (capture) begin
      ck_q <= 8'h00;
    end else if (accept && (phase_q == PhDigit || phase_q == PhSep)) begin
      ck_q <= ck_q ^ byte_val;
    end
  end
`endif

  always_comb begin
    byte_val = 8'h00;
    case (phase_q)
      PhStart: byte_val = 8'h3C;
      PhDigit: byte_val = hex_ascii(cur_q[WIDTH-1 -: 4]);
      PhSep:   byte_val = 8'h7C;
`ifdef HEX_FRAME_SERIALIZER_CK_EN
      PhCkStar: byte_val = 8'h2A;
      PhCkHi:   byte_val = hex_ascii(ck_q[7:4]);
      PhCkLo:   byte_val = hex_ascii(ck_q[3:0]);
`endif
      PhEnd:   byte_val = 8'h3E;
      PhNl:    byte_val = 8'h0A;
      default: byte_val = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_hex_frame_serializer.sv
// Directed bench for hex_frame_serializer: byte scoreboard, backpressure, back-to-back,
// mid-frame reset and a CHANNELS=1/WIDTH=8 instance.
module tb_hex_frame_serializer;
`ifdef HEX_FRAME_SERIALIZER_CK_EN
  localparam int LEN = 3 * 5 + 5;
`else
  localparam int LEN = 3 * 5 + 2;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [15:0] frame_count, frame_count2;
  always #5 clk = ~clk;

  hex_frame_serializer_if #(.CHANNELS(3), .WIDTH(16)) bus ();
  hex_frame_serializer_if #(.CHANNELS(1), .WIDTH(8))  bus2 ();

  hex_frame_serializer #(.CHANNELS(3), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .frame_count(frame_count)
  );
  hex_frame_serializer #(.CHANNELS(1), .WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .frame_count(frame_count2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int nl_cyc   = 0;
  int lt_cyc[$];
  logic [7:0] q[$];
  logic [7:0] q2[$];
  logic [7:0] mon_exp;
  bit         stall = 1'b0;
  logic [7:0] held_d;
  logic       held_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input bit second, input logic [7:0] b);
    if (second) q2.push_back(b);
    else        q.push_back(b);
  endtask

  task automatic push_frame(input int nch, input int w, input logic [63:0] d, input bit second);
    string      hx = "0123456789ABCDEF";
    logic [7:0] ck = 8'h00;
    logic [7:0] b;
    logic [3:0] nib;
    put(second, 8'h3C);
    for (int c = 0; c < nch; c++) begin
      if (c > 0) begin
        put(second, 8'h7C);
        ck = ck ^ 8'h7C;
      end
      for (int g = w / 4 - 1; g >= 0; g--) begin
        nib = d[c*w + g*4 +: 4];
        b   = hx[nib];
        put(second, b);
        ck = ck ^ b;
      end
    end
`ifdef HEX_FRAME_SERIALIZER_CK_EN
    put(second, 8'h2A);
    put(second, hx[ck[7:4]]);
    put(second, hx[ck[3:0]]);
`endif
    put(second, 8'h3E);
    put(second, 8'h0A);
  endtask

  // Scoreboard and stall-stability monitor for the 3x16 instance.
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(held_d));
        check("stall_last", 32'(bus.m_last), 32'(held_l));
      end
      if (bus.m_valid) check("s_ready_in_send", 32'(bus.s_ready), 32'd0);
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          check("unexpected_byte", 32'(bus.m_data), 32'hFFFF_FFFF);
        end else begin
          mon_exp = q.pop_front();
          check("byte", 32'(bus.m_data), 32'(mon_exp));
          check("last", 32'(bus.m_last), 32'(mon_exp == 8'h0A));
          if (mon_exp == 8'h3C) lt_cyc.push_back(cyc);
          if (mon_exp == 8'h0A) nl_cyc = cyc;
        end
        hs_cnt++;
      end
      stall  = bus.m_valid && !bus.m_ready;
      held_d = bus.m_data;
      held_l = bus.m_last;
    end
  end

  task automatic send_sample(input logic [47:0] d, input bit hold);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (n < 200) begin
      @(negedge clk);
      if (bus.s_ready) break;
      n++;
    end
    check("capture_timeout", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    push_frame(3, 16, {16'h0000, d}, 1'b0);
    if (!hold) bus.s_valid = 1'b0;
    bus.s_data = 48'({$urandom(), $urandom()});
  endtask

  task automatic wait_drain(input bit rnd);
    int n = 0;
    while ((q.size() != 0 || bus.m_valid) && n < 500) begin
      @(posedge clk);
      #1;
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    bus.m_ready = 1'b1;
    check("drain_timeout", 32'(n < 500), 32'd1);
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.m_ready = 1'b0;
    #2;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("idle_s_ready", 32'(bus.s_ready), 32'd1);

    // Basic frame, m_ready held high.
    bus.m_ready = 1'b1;
    lt_cyc.delete();
    send_sample({16'h00FF, 16'hABCD, 16'h1234}, 1'b0);
    wait_drain(1'b0);
    check("basic_count", 32'(frame_count), 32'd1);
    check("basic_span", 32'(nl_cyc - lt_cyc[0]), 32'(LEN - 1));

    // Same sample under random backpressure.
    send_sample({16'h00FF, 16'hABCD, 16'h1234}, 1'b0);
    wait_drain(1'b1);
    check("bp_count", 32'(frame_count), 32'd2);

    // Back-to-back with s_valid held.
    lt_cyc.delete();
    send_sample({16'hDEAD, 16'hBEEF, 16'hC0DE}, 1'b1);
    send_sample({16'h0F0F, 16'h9A5C, 16'h7E21}, 1'b0);
    wait_drain(1'b0);
    check("b2b_frames", 32'(lt_cyc.size()), 32'd2);
    check("b2b_period", 32'(lt_cyc[1] - lt_cyc[0]), 32'(LEN + 1));
    check("b2b_count", 32'(frame_count), 32'd4);

    // Checksum-oriented samples.
    send_sample(48'h0, 1'b0);
    wait_drain(1'b0);
    send_sample({16'h0000, 16'h0000, 16'h0001}, 1'b0);
    wait_drain(1'b0);
    check("ck_count", 32'(frame_count), 32'd6);

    // Reset after the 5th byte handshake.
    base = hs_cnt;
    n = 0;
    send_sample({16'h1111, 16'h2222, 16'h3333}, 1'b0);
    while (hs_cnt < base + 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    #1;
    check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    check("midrst_m_data", 32'(bus.m_data), 32'd0);
    check("midrst_m_last", 32'(bus.m_last), 32'd0);
    check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    check("midrst_count", 32'(frame_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_sample({16'hFEDC, 16'hBA98, 16'h7654}, 1'b0);
    wait_drain(1'b0);
    check("post_rst_count", 32'(frame_count), 32'd1);
    check("sb_empty", 32'(q.size()), 32'd0);

    // Degenerate instance: one 8-bit channel.
    bus2.m_ready = 1'b1;
    bus2.s_valid = 1'b1;
    bus2.s_data  = 8'h5A;
    push_frame(1, 8, 64'h5A, 1'b1);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus2.s_ready) break;
      n++;
    end
    check("d2_capture_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    bus2.s_valid = 1'b0;
    bus2.s_data  = 8'hFF;
    n = 0;
    while (q2.size() > 0 && n < 100) begin
      @(negedge clk);
      if (bus2.m_valid) begin
        mon_exp = q2.pop_front();
        check("d2_byte", 32'(bus2.m_data), 32'(mon_exp));
        check("d2_last", 32'(bus2.m_last), 32'(mon_exp == 8'h0A));
      end
      n++;
    end
    check("d2_drain", 32'(q2.size()), 32'd0);
    @(negedge clk);
    check("d2_idle", 32'(bus2.m_valid), 32'd0);
    check("d2_count", 32'(frame_count2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hex_frame_serializer.md
# hex_frame_serializer

Parametrised successor to the fixed three-axis ASCII message path. It captures one multi-channel sample over a valid/ready input and emits it as an ASCII-hex text frame, one byte per handshake, into the UART transmitter's byte stream. The frame has the form `<` ch0 `|` ch1 … `>` `\n`. Channel count and sample width are parameters, and an optional checksum field can be compiled in. The output follows proper backpressure instead of a free-running strobe.

## Interface
- CHANNELS, 3: number of channels per frame; minimum 1.
- WIDTH, 16: bits per channel; multiple of 4. Each channel is printed as D = WIDTH/4 hex digits.
- clk  in  1: sole clock.
- rst  in  1: asynchronous, active-high reset.
- s_valid  in  1: sample offered.
- s_ready  out  1: sample accepted when s_valid & s_ready.
- s_data  in  CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH]. Channel 0 is emitted first.
- m_valid  out  1: output byte valid.
- m_ready  in  1: downstream accepts the byte.
- m_data  out  8: ASCII byte.
- m_last  out  1: high with the final `\n` byte.
- frame_count  out  16: number of completed frames; wraps at 16'hFFFF→0.

## Operation
- Frame length: L = CHANNELS*(D+1)+2. With CK_EN, L = CHANNELS*(D+1)+5.
- Byte order:
  - `<` (0x3C)
  - channel 0 digits, MSB nibble first
  - `|` (0x7C) between channels; none after the last channel
  - `>` (0x3E)
  - `\n` (0x0A)
- Digit encoding: nibble 0–9 → 0x30–0x39; nibble A–F → uppercase 0x41–0x46.
- FSM states:
  - IDLE: s_ready=1, m_valid=0. On s_valid, latch s_data into an internal sample register, clear byte counters, go to SEND.
  - SEND: s_ready=0, m_valid=1. On m_valid & m_ready, advance to the next byte. If the accepted byte is the last one, increment frame_count and return to IDLE.
- Byte position tracking: channel index, digit index, and phase (start / digit / sep / [ck] / end / nl). No division or modulo in logic.
- Latched sample is immune to s_data changes during the frame.
- AXI-stream rules on the output:
  - m_data and m_last are stable while m_valid & !m_ready.
  - m_valid never drops without a handshake, except on reset.
- Reset values: s_ready=0 while rst is high, m_valid=0, m_data=8'h00, m_last=0, frame_count=0, FSM=IDLE.
- Reset mid-frame: the frame is aborted and m_valid clears asynchronously. The partial frame does not count. After reset, the next frame starts at `<`.
- frame_count increments on the `\n` handshake only.

## Timing
- Capture at edge N (s_valid & s_ready) → m_valid=1 with m_data=`<` from edge N+1.
- With m_ready held high: one byte per cycle. The last byte is accepted at edge N+L. s_ready=1 during the cycle after that edge, and the next capture at the earliest is at edge N+L+1.
- Minimum frame period is L+1 cycles. m_valid is low for exactly one cycle between back-to-back frames.
- Input is not buffered. Upstream (stream_fifo) holds s_valid until accepted.
- m_ready low for K cycles extends the frame by exactly K cycles. No byte is lost or duplicated.

## Configuration
- HEX_FRAME_SERIALIZER_CK_EN defined:
  - `*` (0x2A) plus 2 uppercase hex digits are inserted between the last channel's digits and `>`.
  - Checksum value: 8-bit XOR of every byte after `<` up to and including the final channel digit (includes the `|` separators).
  - Accumulated on output handshakes.
  - L grows by 3.
- Not defined: no checksum field, no accumulator logic, and L is the base formula.

## Test plan
- Basic frame: CHANNELS=3, WIDTH=16, ch0=16'h1234, ch1=16'hABCD, ch2=16'h00FF, m_ready=1.
  - Expected bytes: "<1234|ABCD|00FF>\n", 17 bytes on consecutive cycles.
  - m_last high only on 0x0A; frame_count=1.
- Backpressure: same sample, m_ready random at 50%.
  - Identical 17-byte sequence; m_data/m_last constant during every stall.
  - frame_count=1.
- Back-to-back: s_valid held high with two samples queued, m_ready=1.
  - s_ready low during SEND.
  - Second `<` appears 18 cycles after the first `<`, with exactly one m_valid-low cycle between frames.
- Reset mid-frame: assert rst after the 5th byte handshake.
  - m_valid=0 immediately; frame_count stays 0.
  - Next sample produces a complete frame starting with `<`.
- Checksum (macro defined):
  - All-zero sample → "<0000|0000|0000*00>\n", 20 bytes.
  - ch0=16'h0001, ch1 and ch2 zero → checksum field "*01".
  - With the macro undefined, the same samples give 17 bytes with no `*`.
- Degenerate parameters: CHANNELS=1, WIDTH=8, ch0=8'h5A → "<5A>\n", 5 bytes, no `|`.
